// File: rtl/mac_accumulator.sv
// mac_accumulator: streaming signed multiply-accumulate for one neuron output.
// Three-stage pipeline: multiply, accumulate N_TERMS products, scale and
// saturate to Q(OUT_WIDTH-OUT_FRACTION).OUT_FRACTION.
// Optional build macro MAC_ROUND_EN: round half toward +inf before the shift
// (undefined: plain floor truncation). Latency is the same either way.
//
// Handshake: in_valid qualifies x/w for exactly the cycle it is high; there is
// no ready, every valid term is taken. out_ready is a one-cycle strobe that
// marks out (and sat) as new; the consumer must take every strobe.
module mac_accumulator #(
    parameter int DATA_WIDTH      = 12,
    parameter int DATA_FRACTION   = 10,
    parameter int WEIGHT_WIDTH    = 8,
    parameter int WEIGHT_FRACTION = 6,
    parameter int N_TERMS         = 16,
    parameter int ACC_WIDTH       = 32,
    parameter int OUT_WIDTH       = 16,
    parameter int OUT_FRACTION    = 12
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    input  logic signed [DATA_WIDTH-1:0]   x,
    input  logic signed [WEIGHT_WIDTH-1:0] w,
    output logic signed [OUT_WIDTH-1:0] out,
    output logic                        out_ready,
    output logic                        sat,
    output logic                        busy
);

    localparam int PROD_W = DATA_WIDTH + WEIGHT_WIDTH;
    localparam int SHIFT  = DATA_FRACTION + WEIGHT_FRACTION - OUT_FRACTION;
    localparam int CNT_W  = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
    localparam int EXT_W  = ACC_WIDTH + 1;

    logic signed [PROD_W-1:0]    prod_q;
    logic                        prod_v;
    logic [CNT_W-1:0]            cnt;
    logic signed [ACC_WIDTH-1:0] acc;
    logic                        done_v;

    logic signed [ACC_WIDTH-1:0] prod_ext;
    logic signed [EXT_W-1:0]     rounded;
    logic signed [EXT_W-1:0]     scaled;
    logic                        pos_ovf;
    logic                        neg_ovf;
    logic signed [OUT_WIDTH-1:0] sat_val;

    assign prod_ext = {{(ACC_WIDTH-PROD_W){prod_q[PROD_W-1]}}, prod_q};

    // One extra bit of headroom so the rounding add can never wrap.
`ifdef MAC_ROUND_EN
    localparam logic [EXT_W-1:0] RND = (EXT_W'(1) << SHIFT) >> 1;
    assign rounded = {acc[ACC_WIDTH-1], acc} + $signed(RND);
`else
    assign rounded = {acc[ACC_WIDTH-1], acc};
`endif

    assign scaled  = rounded >>> SHIFT;
    // Overflow when the bits above the output sign bit disagree with the sign.
    assign pos_ovf = !scaled[EXT_W-1] && (|scaled[EXT_W-2:OUT_WIDTH-1]);
    assign neg_ovf =  scaled[EXT_W-1] && !(&scaled[EXT_W-2:OUT_WIDTH-1]);

    // Clamp the scaled sum to the output range.
    always_comb begin
        sat_val = scaled[OUT_WIDTH-1:0];
        if (pos_ovf) begin
            sat_val = {1'b0, {(OUT_WIDTH-1){1'b1}}};
        end else if (neg_ovf) begin
            sat_val = {1'b1, {(OUT_WIDTH-1){1'b0}}};
        end
    end

    // Stage 1: register the signed product of the incoming term.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q <= '0;
            prod_v <= 1'b0;
        end else begin
            prod_v <= in_valid;
            if (in_valid) begin
                prod_q <= x * w;
            end
        end
    end

    // Stage 2: accumulate; the first term of a vector loads acc directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            cnt    <= '0;
            done_v <= 1'b0;
        end else begin
            done_v <= 1'b0;
            if (prod_v) begin
                if (cnt == '0) begin
                    acc <= prod_ext;
                end else begin
                    acc <= acc + prod_ext;
                end
                if (cnt == CNT_W'(N_TERMS-1)) begin
                    cnt    <= '0;
                    done_v <= 1'b1;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

    // Stage 3: publish the finished sum; out holds between results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            out_ready <= 1'b0;
            sat       <= 1'b0;
        end else begin
            out_ready <= done_v;
            sat       <= done_v && (pos_ovf || neg_ovf);
            if (done_v) begin
                out <= sat_val;
            end
        end
    end

    assign busy = (cnt != '0) || prod_v || done_v;

endmodule

// File: tb/tb_mac_accumulator.sv
// tb_mac_accumulator: scoreboard bench for mac_accumulator. Expected results
// are computed from the integer dot product when a vector is driven and are
// popped when the DUT strobes out_ready. Honors MAC_ROUND_EN like the DUT.
module tb_mac_accumulator;

    localparam int N_TERMS = 16;
    localparam int SHIFT   = 10 + 6 - 12;

    logic                clk = 1'b0;
    logic                rst_n = 1'b1;
    logic                in_valid = 1'b0;
    logic signed [11:0]  x = '0;
    logic signed [7:0]   w = '0;
    logic signed [15:0]  out;
    logic                out_ready;
    logic                sat;
    logic                busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [15:0] exp_q[$];
    logic        exp_sat_q[$];
    int          exp_cyc_q[$];
    logic [15:0] hold_v = '0;

    mac_accumulator dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .x         (x),
        .w         (w),
        .out       (out),
        .out_ready (out_ready),
        .sat       (sat),
        .busy      (busy)
    );

    // Clock and cycle index (cyc is the number of the current cycle).
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: strobes pop the scoreboard, otherwise out must hold.
    always @(negedge clk) begin
        logic [15:0] e;
        logic        es;
        int          ec;
        if (!rst_n) begin
            hold_v = '0;
            checks++;
            if (out !== 16'h0 || out_ready !== 1'b0 || sat !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs: out=%h out_ready=%b sat=%b busy=%b, required all 0",
                         out, out_ready, sat, busy);
            end
        end else if (out_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: cycle %0d out=%h, no result pending", cyc, out);
                hold_v = out;
            end else begin
                e  = exp_q.pop_front();
                es = exp_sat_q.pop_front();
                ec = exp_cyc_q.pop_front();
                if (out !== e || sat !== es || cyc !== ec) begin
                    errors++;
                    $display("FAIL strobe: out=%h sat=%b cycle=%0d, required out=%h sat=%b cycle=%0d",
                             out, sat, cyc, e, es, ec);
                end
                hold_v = e;
            end
        end else begin
            checks++;
            if (out !== hold_v || sat !== 1'b0 || out_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold: cycle %0d out=%h sat=%b out_ready=%b, required out=%h sat=0 out_ready=0",
                         cyc, out, sat, out_ready, hold_v);
            end
        end
    end

    // Driver: present one input cycle just after the rising edge.
    task automatic drive(input bit v, input logic signed [11:0] xi, input logic signed [7:0] wi);
        @(posedge clk);
        #1;
        in_valid = v;
        x        = xi;
        w        = wi;
    endtask

    // Reference model: integer dot product, optional rounding, floor shift, clamp.
    task automatic push_expected(input longint sum, input int t);
        longint v;
        v = sum;
`ifdef MAC_ROUND_EN
        v = v + (longint'(1) <<< (SHIFT - 1));
`endif
        v = v >>> SHIFT;
        if (v > 32767) begin
            exp_q.push_back(16'h7FFF);
            exp_sat_q.push_back(1'b1);
        end else if (v < -32768) begin
            exp_q.push_back(16'h8000);
            exp_sat_q.push_back(1'b1);
        end else begin
            exp_q.push_back(v[15:0]);
            exp_sat_q.push_back(1'b0);
        end
        exp_cyc_q.push_back(t + 3);
    endtask

    // Drive one vector: term 0 is (x0,w0), the rest (xr,wr); optional idle
    // cycle before each later term; optional busy check every cycle after term 0.
    task automatic send_vector(input logic signed [11:0] x0, input logic signed [7:0] w0,
                               input logic signed [11:0] xr, input logic signed [7:0] wr,
                               input bit gaps, input bit chk_busy);
        longint sum;
        int     t;
        logic signed [11:0] xi;
        logic signed [7:0]  wi;
        sum = 0;
        t   = 0;
        for (int i = 0; i < N_TERMS; i++) begin
            if (gaps && i > 0) begin
                drive(1'b0, 12'sd0, 8'sd0);
                if (chk_busy) begin
                    @(negedge clk);
                    checks++;
                    if (busy !== 1'b1) begin
                        errors++;
                        $display("FAIL busy_gap: term %0d busy=%b, required 1", i, busy);
                    end
                end
            end
            xi = (i == 0) ? x0 : xr;
            wi = (i == 0) ? w0 : wr;
            drive(1'b1, xi, wi);
            sum = sum + longint'(xi) * longint'(wi);
            t   = cyc;
            if (chk_busy && i > 0) begin
                @(negedge clk);
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_term: term %0d busy=%b, required 1", i, busy);
                end
            end
        end
        push_expected(sum, t);
    endtask

    // Stop input and wait (bounded) for all pending strobes.
    task automatic drain();
        drive(1'b0, 12'sd0, 8'sd0);
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) begin
            @(posedge clk);
        end
        @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_strobe: %0d results pending, required 0", exp_q.size());
            exp_q.delete();
            exp_sat_q.delete();
            exp_cyc_q.delete();
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out !== 16'h0 || out_ready !== 1'b0 || sat !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL test_reset: out=%h out_ready=%b sat=%b busy=%b, required all 0",
                     out, out_ready, sat, busy);
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
        drive(1'b0, 12'sd0, 8'sd0);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_busy: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_basic();
        send_vector(12'sh100, 8'sd64, 12'sh100, 8'sd64, 1'b0, 1'b1);
        drain();
    endtask

    task automatic test_saturation();
        send_vector(12'sh400, 8'sd64, 12'sh400, 8'sd64, 1'b0, 1'b0);
        drain();
        send_vector(-12'sh400, 8'sd64, -12'sh400, 8'sd64, 1'b0, 1'b0);
        drain();
        send_vector(12'sh7FF, 8'sd127, 12'sh7FF, -8'sd128, 1'b0, 1'b0);
        drain();
    endtask

    task automatic test_rounding();
        send_vector(12'sd3, 8'sd3, 12'sd0, 8'sd0, 1'b0, 1'b0);
        drain();
        send_vector(-12'sd1, 8'sd8, 12'sd0, 8'sd0, 1'b0, 1'b0);
        drain();
        send_vector(12'sd1, 8'sd8, 12'sd0, 8'sd0, 1'b0, 1'b0);
        drain();
    endtask

    task automatic test_back_to_back();
        send_vector(12'sh100, 8'sd64, 12'sh100, 8'sd64, 1'b0, 1'b0);
        send_vector(12'sh100, -8'sd64, 12'sh100, -8'sd64, 1'b0, 1'b0);
        drain();
    endtask

    task automatic test_gaps();
        send_vector(12'sh100, 8'sd64, 12'sh100, 8'sd64, 1'b1, 1'b1);
        drain();
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            send_vector(12'($urandom_range(0, 4095)), 8'($urandom_range(0, 255)),
                        12'($urandom_range(0, 4095)), 8'($urandom_range(0, 255)),
                        1'b0, 1'b0);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 12'sh7FF, 8'sd127);
        end
        #2 rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++;
        if (out !== 16'h0 || out_ready !== 1'b0 || sat !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: out=%h out_ready=%b sat=%b busy=%b, required all 0",
                     out, out_ready, sat, busy);
        end
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        send_vector(12'sh100, 8'sd64, 12'sh100, 8'sd64, 1'b0, 1'b1);
        drain();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_rounding();
        test_back_to_back();
        test_gaps();
        test_random();
        test_reset_mid();
        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time bound.
    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: simulation did not complete within bound");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
